// File: rtl/result_display.sv
`default_nettype none
// ============================================================================
//  Module      : result_display
//  Description : Captures the 16-bit signed ALU result and overflow flag on
//                LOAD, converts the magnitude to 5 BCD digits with a
//                one-bit-per-clock double-dabble, and drives a 6-digit
//                multiplexed active-low 7-segment display (sign + 5 digits).
//                Optional macro LAMP_TEST_EN adds a LAMP_TEST input that
//                forces every segment on while held.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       R15,
  input  logic       R14,
  input  logic       R13,
  input  logic       R12,
  input  logic       R11,
  input  logic       R10,
  input  logic       R9,
  input  logic       R8,
  input  logic       R7,
  input  logic       R6,
  input  logic       R5,
  input  logic       R4,
  input  logic       R3,
  input  logic       R2,
  input  logic       R1,
  input  logic       R0,
  input  logic       OVF,
  input  logic       LOAD,
`ifdef LAMP_TEST_EN
  input  logic       LAMP_TEST,
`endif
  output logic       BUSY,
  output logic       DONE,
  output logic [6:0] SEG,
  output logic [5:0] AN
);

  // State encoding
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CONV = 2'd1;
  localparam logic [1:0] c_SHOW = 2'd2;

  // Segment codes, active-low gfedcba
  localparam logic [6:0] c_SEG_BLANK = 7'h7F;
  localparam logic [6:0] c_SEG_MINUS = 7'h3F;
  localparam logic [6:0] c_SEG_E     = 7'h06;
  localparam logic [6:0] c_SEG_R     = 7'h2F;

  localparam int                    c_SCAN_W   = $clog2(SCAN_DIV);
  localparam logic [c_SCAN_W-1:0]   c_SCAN_MAX = c_SCAN_W'(SCAN_DIV - 1);

  logic [1:0]          r_state;
  logic [15:0]         r_mag;
  logic [19:0]         r_bcd;
  logic [4:0]          r_cnt;
  logic                r_neg;
  logic                r_err;
  logic                r_busy;
  logic                r_done;
  logic [5:0][6:0]     r_dig;
  logic [c_SCAN_W-1:0] r_scan;
  logic [2:0]          r_idx;
  logic [6:0]          r_seg;
  logic [5:0]          r_an;

  logic [15:0]         w_r;
  logic [15:0]         w_mag;
  logic [19:0]         w_bcd_adj;
  logic [5:0][6:0]     w_disp;
  logic                w_lamp;

  assign w_r = {R15, R14, R13, R12, R11, R10, R9, R8,
                R7,  R6,  R5,  R4,  R3,  R2,  R1, R0};

  // Two's-complement magnitude; 0x8000 maps to 32768 as unsigned
  assign w_mag = w_r[15] ? (~w_r + 16'd1) : w_r;

`ifdef LAMP_TEST_EN
  assign w_lamp = LAMP_TEST;
`else
  assign w_lamp = 1'b0;
`endif

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = c_SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 5; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Build the next display image with leading-zero blanking and sign
  always_comb begin
    logic nz4, nz3, nz2, nz1;
    nz4 = (r_bcd[19:16] != 4'd0);
    nz3 = nz4 | (r_bcd[15:12] != 4'd0);
    nz2 = nz3 | (r_bcd[11:8]  != 4'd0);
    nz1 = nz2 | (r_bcd[7:4]   != 4'd0);
    w_disp[5] = r_neg ? c_SEG_MINUS : c_SEG_BLANK;
    w_disp[4] = nz4 ? seg_of(r_bcd[19:16]) : c_SEG_BLANK;
    w_disp[3] = nz3 ? seg_of(r_bcd[15:12]) : c_SEG_BLANK;
    w_disp[2] = nz2 ? seg_of(r_bcd[11:8])  : c_SEG_BLANK;
    w_disp[1] = nz1 ? seg_of(r_bcd[7:4])   : c_SEG_BLANK;
    w_disp[0] = seg_of(r_bcd[3:0]);
    if (r_err) begin
      w_disp = {c_SEG_BLANK, c_SEG_BLANK, c_SEG_BLANK, c_SEG_E, c_SEG_R, c_SEG_R};
    end
  end

  // Capture / convert / publish FSM. An overflow load enters CONV with the
  // bit counter already at 16, so it publishes "Err" on the very next edge.
  // BUSY drops with the final shift; the following edge publishes the digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_mag   <= 16'd0;
      r_bcd   <= 20'd0;
      r_cnt   <= 5'd0;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dig   <= {6{c_SEG_BLANK}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE, c_SHOW: begin
          if (LOAD) begin
            r_state <= c_CONV;
            r_bcd   <= 20'd0;
            if (OVF) begin
              r_err <= 1'b1;
              r_cnt <= 5'd16;
            end else begin
              r_err  <= 1'b0;
              r_cnt  <= 5'd0;
              r_mag  <= w_mag;
              r_neg  <= w_r[15];
              r_busy <= 1'b1;
            end
          end
        end
        c_CONV: begin
          if (r_cnt == 5'd16) begin
            r_dig   <= w_disp;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= c_SHOW;
          end else begin
            {r_bcd, r_mag} <= {w_bcd_adj[18:0], r_mag, 1'b0};
            r_cnt          <= r_cnt + 5'd1;
            if (r_cnt == 5'd15) begin
              r_busy <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Free-running scan prescaler and digit index 0..5
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan <= '0;
      r_idx  <= 3'd0;
    end else if (r_scan == c_SCAN_MAX) begin
      r_scan <= '0;
      r_idx  <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_scan <= r_scan + c_SCAN_W'(1);
    end
  end

  // Registered segment and anode drivers for the selected digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= c_SEG_BLANK;
      r_an  <= 6'h3F;
    end else begin
      r_an  <= ~(6'd1 << r_idx);
      r_seg <= w_lamp ? 7'h00 : r_dig[r_idx];
    end
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign SEG  = r_seg;
  assign AN   = r_an;

endmodule
`default_nettype wire

// File: doc/result_display.md
Name: result_display

Overview:
- Consumer end of the calculator ALU result bus.
- Captures the 16-bit signed result R15..R0 and the OVF flag on a load strobe.
- Converts the result iteratively to sign plus 5 BCD digits using double-dabble, one bit per clock.
- Drives a 6-digit multiplexed 7-segment display.

Parameters:
- SCAN_DIV, 1000: clocks each digit stays active before the scan advances (must be >= 2).

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- R15..R0  input  1 each (x16)  ALU result, two's complement; R15 is the sign bit
- OVF  input  1  ALU overflow/error flag
- LOAD  input  1  capture strobe; sampled on clk rising edge
- BUSY  output  1  high while converting
- DONE  output  1  one-cycle pulse when the displayed value has been updated
- SEG[6:0]  output  7  segments gfedcba, active-low
- AN[5:0]  output  6  digit enables, active-low one-hot; AN[0]=ones … AN[4]=ten-thousands, AN[5]=sign

Behaviour:
- Decided: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state=IDLE, BUSY=0, DONE=0.
  - All display digit registers hold BLANK.
  - Scan counter=0, digit index=0, SEG=7'h7F, AN=6'h3F.
  - Outputs take these values immediately on rst_n low, including mid-conversion.
- States: IDLE, CONV, SHOW.
- IDLE/SHOW with LOAD=1 and OVF=0:
  - Latch magnitude = |R|. 0x8000 gives magnitude 32768 as a 16-bit unsigned value.
  - Latch neg = R15.
  - Clear the 20-bit BCD accumulator and the bit counter; go to CONV; BUSY=1.
- IDLE/SHOW with LOAD=1 and OVF=1:
  - No conversion. Next edge: display regs = {BLANK,BLANK,BLANK,E,r,r} (AN[5]..AN[0]).
  - DONE pulses 1 cycle; state SHOW; BUSY stays 0.
- CONV, per clock:
  - Add 3 to each BCD nibble >= 5.
  - Shift {bcd, magnitude} left by 1.
  - After 16 shifts, update the display regs on the following edge; DONE=1 for that one cycle; BUSY=0; state SHOW.
- Latency:
  - DONE is high exactly 17 cycles after the edge that sampled LOAD (OVF case: 1 cycle).
  - Back-to-back loads are accepted starting in the DONE cycle.
- LOAD while in CONV is ignored. There is no queueing.
- Display register update rules:
  - Leading-zero blanking: digit 4..1 is BLANK if it and every higher magnitude digit are zero.
  - Digit 0 always shows, so value 0 displays "0".
  - Sign digit: '-' if neg, else BLANK.
- Display regs change only at the DONE cycle. During CONV the previous value stays on the display.
- Scan:
  - Free-running counter 0..SCAN_DIV-1.
  - At wrap, the digit index advances 0→1→…→5→0.
  - AN = ~(1<<index); SEG = code of the selected digit register.
  - Scanning runs in all states.
  - SEG/AN are registered (1-cycle delay from index change).
- Segment codes (active-low, gfedcba):
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Symbols: '-'=3F, E=06, r=2F, BLANK=7F.
- The ALU's DIV packing (quotient/remainder bytes) is displayed as a plain 16-bit signed value. No special handling.

Optional Feature:
- Macro LAMP_TEST_EN.
- When defined:
  - Adds input port LAMP_TEST (1 bit).
  - While LAMP_TEST=1, SEG=7'h00 for whichever digit is active; scanning and AN are unchanged.
  - Conversion and display regs are unaffected; releasing LAMP_TEST restores the stored digits within 1 cycle.
- When undefined: the port is absent and SEG is always derived from the display regs.

Test Plan:
- R=0x007B, OVF=0, LOAD 1 cycle → BUSY high for 16 cycles; DONE at cycle 17; digits AN5..AN0 = BLANK,BLANK,BLANK,1,2,3; SEG for AN0 = 0x30.
- R=0xFF85 (-123) → sign digit 0x3F ('-'), magnitude digits BLANK,BLANK,1,2,3. R=0x8000 → '-',3,2,7,6,8.
- R=0x0000 → only AN0 shows 0x40, all others 0x7F. R=0x7FFF → 3,2,7,6,7 with blank sign.
- OVF=1 with arbitrary R, LOAD → DONE one cycle later; display BLANK,BLANK,BLANK,E,r,r; BUSY never asserts.
- LOAD 123 → LOAD 456 at cycle 5 of CONV → ignored, 123 displayed at cycle 17. Then LOAD 456 during CONV with rst_n pulsed low at cycle 8 → all outputs at reset values asynchronously; after release, no DONE until a new LOAD.
- With SCAN_DIV=4: AN sequence 3E,3D,3B,37,2F,1F repeats every 24 cycles. With LAMP_TEST_EN: LAMP_TEST=1 forces SEG=00 on every digit.
